writeback_buffer: RTL and testbench

- Sits between the execute/memory stages and the 8-entry x 8-bit register file's single write port; accepts register write requests via valid/ready and drains them in order, one per granted cycle.
- Gives the two register-file read ports a bypass path: pending (not yet retired) writes are forwarded, so readers never see stale data.
- Address 0 is hard-wired zero in the register file, and so is never queued or forwarded.

---
 rtl/writeback_buffer_pkg.sv | 20 ++
 rtl/writeback_buffer_bypass.sv | 34 +++
 rtl/writeback_buffer.sv | 106 ++++++++++
 tb/tb_writeback_buffer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_buffer_pkg.sv
// rtl/writeback_buffer_pkg.sv - shared constants and entry record for the writeback buffer
package writeback_buffer_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 8;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Register 0 is hard-wired and anything past NUM_REGS does not exist.
  function automatic logic is_legal_adr(input logic [ADDR_W-1:0] adr);
    return (adr != REG_ZERO) && (adr < ADDR_W'(NUM_REGS));
  endfunction

endpackage

// File: rtl/writeback_buffer_bypass.sv
// rtl/writeback_buffer_bypass.sv - youngest-match search over the pending write entries
module wb_bypass_match
  import writeback_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  entry_t [DEPTH-1:0] entries_i,
  input  logic [PW-1:0]      head_i,
  input  logic [CW-1:0]      count_i,
  input  logic [ADDR_W-1:0]  look_adr_i,
  output logic               hit_o,
  output logic [DATA_W-1:0]  fwd_data_o
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit_o      = 1'b0;
    fwd_data_o = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if ((CW'(i) < count_i) && entries_i[idx].valid &&
          (entries_i[idx].adr == look_adr_i) && (look_adr_i != REG_ZERO)) begin
        hit_o      = 1'b1;
        fwd_data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - in-order register write queue with read-port bypass
module writeback_buffer
  import writeback_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   reqValid,
  output logic                   reqReady,
  input  logic [ADDR_W-1:0]      reqAdr,
  input  logic [DATA_W-1:0]      reqData,
  input  logic                   rfGrant,
  output logic                   writeEn,
  output logic [ADDR_W-1:0]      writeAdr,
  output logic [DATA_W-1:0]      writeData,
  input  logic [ADDR_W-1:0]      lookAdr1,
  input  logic [ADDR_W-1:0]      lookAdr2,
  output logic                   hit1,
  output logic                   hit2,
  output logic [DATA_W-1:0]      fwdData1,
  output logic [DATA_W-1:0]      fwdData2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic               push, pop;
  entry_t             head_entry;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign count      = count_q;
  assign reqReady   = !full && !flush;
  assign writeEn    = !empty && rfGrant && !flush;
  assign pop        = writeEn;
  // Illegal destinations still complete the handshake; they just never land.
  assign push       = reqValid && reqReady && is_legal_adr(reqAdr);
  assign head_entry = entries_q[head_q];
  assign writeAdr   = empty ? '0 : head_entry.adr;
  assign writeData  = empty ? '0 : head_entry.data;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
    end else begin
      if (pop) begin
        entries_d[head_q].valid = 1'b0;
        head_d = head_q + PW'(1);
      end
      if (push) begin
        entries_d[tail_q] = '{valid: 1'b1, adr: reqAdr, data: reqData};
        tail_d = tail_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  wb_bypass_match #(.DEPTH(DEPTH)) u_match1 (
    .entries_i (entries_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .look_adr_i(lookAdr1),
    .hit_o     (hit1),
    .fwd_data_o(fwdData1)
  );

  wb_bypass_match #(.DEPTH(DEPTH)) u_match2 (
    .entries_i (entries_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .look_adr_i(lookAdr2),
    .hit_o     (hit2),
    .fwd_data_o(fwdData2)
  );

endmodule

// File: tb/tb_writeback_buffer.sv
// tb/tb_writeback_buffer.sv - self-checking bench for writeback_buffer
module tb_writeback_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       reqValid = 1'b0;
  logic       reqReady;
  logic [3:0] reqAdr = '0;
  logic [7:0] reqData = '0;
  logic       rfGrant = 1'b0;
  logic       writeEn;
  logic [3:0] writeAdr;
  logic [7:0] writeData;
  logic [3:0] lookAdr1 = '0;
  logic [3:0] lookAdr2 = '0;
  logic       hit1, hit2;
  logic [7:0] fwdData1, fwdData2;
  logic [2:0] count;
  logic       empty, full;

  int checks = 0;
  int failures = 0;

  writeback_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .reqValid(reqValid), .reqReady(reqReady), .reqAdr(reqAdr), .reqData(reqData),
    .rfGrant(rfGrant), .writeEn(writeEn), .writeAdr(writeAdr), .writeData(writeData),
    .lookAdr1(lookAdr1), .lookAdr2(lookAdr2),
    .hit1(hit1), .hit2(hit2), .fwdData1(fwdData1), .fwdData2(fwdData2),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic [3:0] adr;
    logic [7:0] data;
    logic       gnt;
    logic       fl;
    logic [3:0] l1, l2;
    logic       e_we;
    logic [3:0] e_wa;
    logic [7:0] e_wd;
    logic       e_h1;
    logic [7:0] e_f1;
    logic       e_h2;
    logic [7:0] e_f2;
    int         e_cnt;
    logic       e_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [3:0] adr, input logic [7:0] data,
                     input logic gnt, input logic fl, input logic [3:0] l1, input logic [3:0] l2,
                     input logic e_we, input logic [3:0] e_wa, input logic [7:0] e_wd,
                     input logic e_h1, input logic [7:0] e_f1, input logic e_h2, input logic [7:0] e_f2,
                     input int e_cnt, input logic e_rdy);
    vec_t t;
    t = '{v, adr, data, gnt, fl, l1, l2, e_we, e_wa, e_wd, e_h1, e_f1, e_h2, e_f2, e_cnt, e_rdy};
    vecs.push_back(t);
  endtask

  typedef struct {
    logic [3:0] adr;
    logic [7:0] data;
  } m_t;

  m_t mq[$];

  task automatic model_look(input logic [3:0] a, output logic h, output logic [7:0] d);
    h = 1'b0;
    d = '0;
    if (a != 0)
      for (int k = mq.size() - 1; k >= 0; k--)
        if (mq[k].adr == a) begin
          h = 1'b1;
          d = mq[k].data;
          break;
        end
  endtask

  initial begin
    logic       mh1, mh2, m_we, m_rdy, m_fire;
    logic [7:0] mf1, mf2;

    // Reset held with the clock running
    repeat (3) @(posedge clk);
    #1;
    chk("reset_we", writeEn, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_ready", reqReady, 1);
    chk("reset_hit1", hit1, 0);
    chk("reset_count", count, 0);
    chk("reset_wadr", writeAdr, 0);
    chk("reset_fwd1", fwdData1, 0);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_we", writeEn, 0);
      chk("idle_empty", empty, 1);
    end

    // v  adr data gnt fl l1 l2  we wa wd    h1 f1    h2 f2    cnt rdy
    add(1, 3, 8'h11, 0, 0, 3, 5, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1);
    add(1, 5, 8'h22, 0, 0, 3, 5, 0, 3, 8'h11, 1, 8'h11, 0, 8'h00, 1, 1);
    add(1, 3, 8'h33, 0, 0, 3, 5, 0, 3, 8'h11, 1, 8'h11, 1, 8'h22, 2, 1);
    add(0, 0, 8'h00, 0, 0, 3, 5, 0, 3, 8'h11, 1, 8'h33, 1, 8'h22, 3, 1);
    add(0, 0, 8'h00, 0, 0, 0, 5, 0, 3, 8'h11, 0, 8'h00, 1, 8'h22, 3, 1);
    add(0, 0, 8'h00, 1, 0, 3, 5, 1, 3, 8'h11, 1, 8'h33, 1, 8'h22, 3, 1);
    add(0, 0, 8'h00, 1, 0, 3, 5, 1, 5, 8'h22, 1, 8'h33, 1, 8'h22, 2, 1);
    add(0, 0, 8'h00, 1, 0, 3, 5, 1, 3, 8'h33, 1, 8'h33, 0, 8'h00, 1, 1);
    add(0, 0, 8'h00, 1, 0, 3, 5, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1);
    add(1, 0, 8'hAA, 0, 0, 0, 9, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1);
    add(1, 9, 8'hBB, 0, 0, 0, 9, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 9, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1);
    add(1, 1, 8'hA1, 0, 0, 2, 6, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1);
    add(1, 2, 8'hA2, 0, 0, 2, 6, 0, 1, 8'hA1, 0, 8'h00, 0, 8'h00, 1, 1);
    add(1, 4, 8'hA4, 0, 0, 2, 6, 0, 1, 8'hA1, 1, 8'hA2, 0, 8'h00, 2, 1);
    add(1, 6, 8'hA6, 0, 0, 2, 6, 0, 1, 8'hA1, 1, 8'hA2, 0, 8'h00, 3, 1);
    add(1, 7, 8'hA7, 0, 0, 2, 6, 0, 1, 8'hA1, 1, 8'hA2, 1, 8'hA6, 4, 0);
    add(1, 7, 8'hA7, 1, 0, 7, 6, 1, 1, 8'hA1, 0, 8'h00, 1, 8'hA6, 4, 0);
    add(1, 7, 8'hA7, 1, 0, 7, 1, 1, 2, 8'hA2, 0, 8'h00, 0, 8'h00, 3, 1);
    add(1, 5, 8'hB5, 0, 0, 7, 1, 0, 4, 8'hA4, 1, 8'hA7, 0, 8'h00, 3, 1);
    add(0, 0, 8'h00, 0, 0, 5, 4, 0, 4, 8'hA4, 1, 8'hB5, 1, 8'hA4, 4, 0);
    add(1, 3, 8'hC3, 1, 1, 5, 4, 0, 4, 8'hA4, 1, 8'hB5, 1, 8'hA4, 4, 0);
    add(0, 0, 8'h00, 1, 0, 5, 4, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1);

    foreach (vecs[i]) begin
      reqValid = vecs[i].v;   reqAdr = vecs[i].adr; reqData = vecs[i].data;
      rfGrant = vecs[i].gnt;  flush = vecs[i].fl;
      lookAdr1 = vecs[i].l1;  lookAdr2 = vecs[i].l2;
      #2;
      chk($sformatf("v%0d_we", i), writeEn, vecs[i].e_we);
      chk($sformatf("v%0d_wadr", i), writeAdr, vecs[i].e_wa);
      chk($sformatf("v%0d_wdata", i), writeData, vecs[i].e_wd);
      chk($sformatf("v%0d_hit1", i), hit1, vecs[i].e_h1);
      chk($sformatf("v%0d_fwd1", i), fwdData1, vecs[i].e_f1);
      chk($sformatf("v%0d_hit2", i), hit2, vecs[i].e_h2);
      chk($sformatf("v%0d_fwd2", i), fwdData2, vecs[i].e_f2);
      chk($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
      chk($sformatf("v%0d_ready", i), reqReady, vecs[i].e_rdy);
      chk($sformatf("v%0d_full", i), full, vecs[i].e_cnt == DEPTH);
      @(posedge clk); #1;
    end

    // Async reset mid-cycle drops pending writes without an edge
    reqValid = 1; rfGrant = 0; flush = 0; reqAdr = 3; reqData = 8'hD3;
    @(posedge clk); #1;
    reqAdr = 5; reqData = 8'hD5;
    @(posedge clk); #1;
    reqValid = 0; rfGrant = 1; lookAdr1 = 3; lookAdr2 = 5;
    #2;
    chk("arst_pre_count", count, 2);
    chk("arst_pre_we", writeEn, 1);
    rst = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_we", writeEn, 0);
    chk("arst_empty", empty, 1);
    chk("arst_hit1", hit1, 0);
    chk("arst_ready", reqReady, 1);
    @(posedge clk); #1;
    rst = 1'b1; rfGrant = 0;

    // Flush with two entries pending and a grant present
    reqValid = 1; reqAdr = 2; reqData = 8'hE2;
    @(posedge clk); #1;
    reqAdr = 6; reqData = 8'hE6;
    @(posedge clk); #1;
    reqValid = 0; flush = 1; rfGrant = 1;
    #2;
    chk("flush_we", writeEn, 0);
    chk("flush_ready", reqReady, 0);
    @(posedge clk); #1;
    flush = 0;
    #1;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_we_after", writeEn, 0);

    // Random traffic against a queue model
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      reqValid = ($urandom_range(0, 9) < 7);
      reqAdr   = 4'($urandom_range(0, 9));
      reqData  = 8'($urandom);
      rfGrant  = $urandom_range(0, 1);
      flush    = ($urandom_range(0, 15) == 0);
      lookAdr1 = 4'($urandom_range(0, 9));
      lookAdr2 = 4'($urandom_range(0, 9));
      #2;
      m_rdy  = (mq.size() < DEPTH) && !flush;
      m_we   = (mq.size() > 0) && rfGrant && !flush;
      m_fire = reqValid && m_rdy;
      model_look(lookAdr1, mh1, mf1);
      model_look(lookAdr2, mh2, mf2);
      chk("rnd_ready", reqReady, m_rdy);
      chk("rnd_we", writeEn, m_we);
      chk("rnd_wadr", writeAdr, mq.size() > 0 ? int'(mq[0].adr) : 0);
      chk("rnd_wdata", writeData, mq.size() > 0 ? int'(mq[0].data) : 0);
      chk("rnd_hit1", hit1, mh1);
      chk("rnd_fwd1", fwdData1, mf1);
      chk("rnd_hit2", hit2, mh2);
      chk("rnd_fwd2", fwdData2, mf2);
      chk("rnd_count", count, mq.size());
      chk("rnd_empty", empty, mq.size() == 0);
      if (flush) mq.delete();
      else begin
        if (m_we) void'(mq.pop_front());
        if (m_fire && reqAdr != 0 && reqAdr < 8) mq.push_back('{reqAdr, reqData});
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
